// File: rtl/mostrar_resultado_pkg.sv
// pkg_despliegue: FSM states, 7-segment patterns and BCD helpers for mostrar_resultado
package pkg_despliegue;
    typedef enum logic [1:0] {IDLE, CONV, CARGA} estado_t;
    localparam int N_BCD = 5;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MENOS = 7'b0111111;
    localparam logic [6:0] SEG_DIG [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    function automatic logic [6:0] seg_de(input logic [3:0] d);
        return d > 4'd9 ? SEG_BLANK : SEG_DIG[d];
    endfunction
    // Double-dabble correction: every nibble >= 5 gets +3 before the shift
    function automatic logic [4*N_BCD-1:0] ajustar(input logic [4*N_BCD-1:0] b);
        logic [4*N_BCD-1:0] r;
        for (int i = 0; i < N_BCD; i++)
            r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/mostrar_resultado_if.sv
// mostrar_resultado_if: product handshake between the multiplier and the display block
interface mostrar_resultado_if;
    logic [15:0] producto;
    logic        valido;
    logic        ocupado;
    modport master (output producto, valido, input ocupado);
    modport slave (input producto, valido, output ocupado);
endinterface

// File: rtl/mostrar_resultado_binario_bcd.sv
// binario_bcd: sequential 16-bit binary to 5-digit BCD converter, one bit per clock
module binario_bcd
    import pkg_despliegue::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          valor,
    output logic [4*N_BCD-1:0]   bcd,
    output logic                 done
);
    logic [15:0] sh;
    logic [3:0]  cnt;
    logic        activo;
    // done marks the cycle of the last iteration so the caller can leave CONV on that edge
    assign done = activo && cnt == 4'd15;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bcd    <= '0;
            sh     <= '0;
            cnt    <= '0;
            activo <= 1'b0;
        end else if (start) begin
            bcd    <= '0;
            sh     <= valor;
            cnt    <= '0;
            activo <= 1'b1;
        end else if (activo) begin
            {bcd, sh} <= {ajustar(bcd), sh} << 1;
            cnt       <= cnt + 4'd1;
            activo    <= !done;
        end
endmodule

// File: rtl/mostrar_resultado.sv
// mostrar_resultado: signed product to sign + BCD, shown on a multiplexed 8-digit 7-segment display
module mostrar_resultado
    import pkg_despliegue::*;
#(
    parameter int REFRESH_LIMIT = 99999,
    parameter int N_DIGITS      = 8
) (
    input  logic                CLK100MHZ,
    input  logic                reset,
    mostrar_resultado_if.slave  bus,
    output logic [6:0]          seg,
    output logic                DP,
    output logic [N_DIGITS-1:0] AN
);
    localparam int CW = REFRESH_LIMIT > 0 ? $clog2(REFRESH_LIMIT + 1) : 1;
    localparam int IW = $clog2(N_DIGITS);
    estado_t              estado;
    logic                 ocupado;
    logic                 signo;
    logic                 disp_signo;
    logic [4*N_BCD-1:0]   disp_bcd;
    logic [4*N_BCD-1:0]   bcd;
    logic [15:0]          mag;
    logic                 start;
    logic                 done;
    logic [CW-1:0]        refresco;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_n;
    logic                 fin;
    logic [6:0]           pat [N_DIGITS];
    assign DP          = 1'b1;
    assign bus.ocupado = ocupado;
    assign start       = estado == IDLE && bus.valido;
    // -32768 negates to 16'h8000, which is exactly 32768 as unsigned
    assign mag         = bus.producto[15] ? -bus.producto : bus.producto;
    binario_bcd u_bcd (
        .clk   (CLK100MHZ),
        .rst_n (reset),
        .start (start),
        .valor (mag),
        .bcd   (bcd),
        .done  (done)
    );
    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) begin
            estado     <= IDLE;
            ocupado    <= 1'b0;
            signo      <= 1'b0;
            disp_signo <= 1'b0;
            disp_bcd   <= '0;
        end else if (start) begin
            estado  <= CONV;
            ocupado <= 1'b1;
            signo   <= bus.producto[15];
        end else if (estado == CONV && done) begin
            estado <= CARGA;
        end else if (estado == CARGA) begin
            estado     <= IDLE;
            ocupado    <= 1'b0;
            disp_bcd   <= bcd;
            disp_signo <= signo;
        end
    assign fin   = refresco == CW'(REFRESH_LIMIT);
    assign idx_n = fin ? (idx == IW'(N_DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
    // A digit is blanked when it and every more significant digit are zero; digit 0 always shows
    always_comb begin
        for (int i = 0; i < N_DIGITS; i++)
            pat[i] = SEG_BLANK;
        for (int i = 0; i < N_BCD; i++)
            pat[i] = (i > 0 && (disp_bcd >> (4 * i)) == '0) ? SEG_BLANK : seg_de(disp_bcd[4*i +: 4]);
        pat[N_BCD] = disp_signo ? SEG_MENOS : SEG_BLANK;
    end
    // seg and AN both follow idx_n on the same edge, so they never disagree
    always_ff @(posedge CLK100MHZ or negedge reset)
        if (!reset) begin
            refresco <= '0;
            idx      <= '0;
            AN       <= ~N_DIGITS'(1);
            seg      <= SEG_DIG[0];
        end else begin
            refresco <= fin ? '0 : refresco + CW'(1);
            idx      <= idx_n;
            AN       <= ~(N_DIGITS'(1) << idx_n);
            seg      <= pat[idx_n];
        end
endmodule

// File: tb/tb_mostrar_resultado.sv
// tb_mostrar_resultado: directed checks of conversion, scanning, blanking and reset
module tb_mostrar_resultado;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000, BL = 7'b1111111, MN = 7'b0111111;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    logic [6:0] frame [8];
    int         checks = 0;
    int         passed = 0;
    mostrar_resultado_if bus ();
    mostrar_resultado #(.REFRESH_LIMIT(3), .N_DIGITS(8)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (bus),
        .seg       (seg),
        .DP        (dp),
        .AN        (an)
    );
    always #5 clk = ~clk;

    task automatic pulso(input logic [15:0] p);
        @(negedge clk);
        bus.producto = p;
        bus.valido   = 1'b1;
        @(negedge clk);
        bus.valido   = 1'b0;
    endtask

    task automatic contar_ocupado(output int n);
        n = 0;
        while (bus.ocupado && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic capturar();
        for (int j = 0; j < 8; j++) frame[j] = 'x;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++)
                if (an == ~(8'b1 << j)) frame[j] = seg;
        end
    endtask

    task automatic test_reset();
        pulso(16'd16384);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (an !== 8'hFE) $display("FAIL reset_an got %h expected fe", an); else passed++;
        checks++; if (seg !== S0) $display("FAIL reset_seg got %b expected %b", seg, S0); else passed++;
        checks++; if (dp !== 1'b1) $display("FAIL reset_dp got %b expected 1", dp); else passed++;
        checks++; if (bus.ocupado !== 1'b0) $display("FAIL reset_ocupado got %b expected 0", bus.ocupado); else passed++;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_conversion();
        logic [6:0] e [8];
        logic [7:0] prev;
        int n, last;
        bit wrap;
        e = '{S4, S8, S3, S6, S1, BL, BL, BL};
        pulso(16'd16384);
        contar_ocupado(n);
        checks++; if (n !== 17) $display("FAIL busy_16384 got %0d cycles expected 17", n); else passed++;
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL d16384_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
        prev = an;
        last = -1;
        wrap = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (an !== prev) begin
                checks++;
                if (an !== {prev[6:0], prev[7]} || (last >= 0 && c - last != 4))
                    $display("FAIL scan_step got %h after %h (%0d clocks) expected %h after 4", an, prev, c - last, {prev[6:0], prev[7]});
                else passed++;
                if (prev == 8'h7F && an == 8'hFE) wrap = 1;
                last = c;
                prev = an;
            end
        end
        checks++; if (!wrap) $display("FAIL scan_wrap got no 7f->fe transition expected one"); else passed++;
    endtask

    task automatic test_negative();
        logic [6:0] e [8];
        int n;
        e = '{S6, S5, S2, S6, S1, MN, BL, BL};
        pulso(16'hC080);
        contar_ocupado(n);
        checks++; if (n !== 17) $display("FAIL busy_m16256 got %0d cycles expected 17", n); else passed++;
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL dm16256_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
    endtask

    task automatic test_boundaries();
        logic [6:0] e [8];
        int n;
        e = '{S8, S6, S7, S2, S3, MN, BL, BL};
        pulso(16'h8000);
        contar_ocupado(n);
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL dm32768_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
        e = '{S7, BL, BL, BL, BL, BL, BL, BL};
        pulso(16'd7);
        contar_ocupado(n);
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL d7_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
        e = '{S0, BL, BL, BL, BL, BL, BL, BL};
        pulso(16'd0);
        contar_ocupado(n);
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL d0_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e [8];
        int n;
        e = '{S0, S0, S1, BL, BL, BL, BL, BL};
        pulso(16'd100);
        @(negedge clk);
        pulso(-16'sd5);
        contar_ocupado(n);
        checks++; if (n !== 14) $display("FAIL busy_dropped got %0d cycles expected 14", n); else passed++;
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL d100_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [6:0] e [8];
        int n;
        pulso(16'd1234);
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (an !== 8'hFE) $display("FAIL midreset_an got %h expected fe", an); else passed++;
        checks++; if (seg !== S0) $display("FAIL midreset_seg got %b expected %b", seg, S0); else passed++;
        checks++; if (bus.ocupado !== 1'b0) $display("FAIL midreset_ocupado got %b expected 0", bus.ocupado); else passed++;
        @(negedge clk) reset = 1'b1;
        e = '{S0, BL, BL, BL, BL, BL, BL, BL};
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL postreset_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
        e = '{S2, S4, BL, BL, BL, BL, BL, BL};
        pulso(16'd42);
        contar_ocupado(n);
        checks++; if (n !== 17) $display("FAIL busy_42 got %0d cycles expected 17", n); else passed++;
        capturar();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (frame[j] !== e[j]) $display("FAIL d42_digit%0d got %b expected %b", j, frame[j], e[j]); else passed++;
        end
    endtask

    initial begin
        bus.producto = '0;
        bus.valido   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_conversion();
        test_negative();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
